// File: rtl/pco_bank_if.sv
// Control and output bundle of the phase-controlled oscillator bank.
// The control side drives phase words and prescaler; the bank returns the waveforms.
interface pco_bank_if #(
    parameter int N_OSC = 4,
    parameter int PH_W  = 4,
    parameter int DIV_W = 8
);
    logic                    en;
    logic [DIV_W-1:0]        div;
    logic [N_OSC*PH_W-1:0]   phi_in;
    logic                    phi_load;
    logic                    busy;
    logic [N_OSC-1:0]        nout;
    logic [PH_W-1:0]         phase_cnt;
    logic                    tick;
    logic                    sync;

    modport master (
        output en, div, phi_in, phi_load,
        input  busy, nout, phase_cnt, tick, sync
    );

    modport slave (
        input  en, div, phi_in, phi_load,
        output busy, nout, phase_cnt, tick, sync
    );
endinterface

// File: rtl/pco_bank.sv
// Bank of N_OSC 50%-duty square-wave oscillators sharing one prescaled phase counter.
// Phase words are double-buffered and only take effect at the period boundary.
module pco_bank #(
    parameter int N_OSC = 4,
    parameter int PH_W  = 4,
    parameter int DIV_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    pco_bank_if.slave bus
);
    localparam logic [PH_W-1:0] PH_MAX = '1;

    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [N_OSC*PH_W-1:0] act_q, act_d;
    logic [N_OSC*PH_W-1:0] shadow_q, shadow_d;
    logic                  busy_q, busy_d;
    logic                  tick_q, sync_q;
    logic [N_OSC-1:0]      nout_q, nout_d;
    logic                  tick_ev;
    logic                  boundary;

    always_comb begin
        tick_ev  = bus.en && (cnt_q >= bus.div);
        boundary = tick_ev && (phase_q == PH_MAX);
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        busy_d   = busy_q;
        if (bus.en) begin
            cnt_d = tick_ev ? '0 : cnt_q + 1'b1;
        end
        if (tick_ev) begin
            phase_d = phase_q + 1'b1;
        end
        // A load that lands on the boundary bypasses the shadow wait entirely.
        if (bus.phi_load) begin
            shadow_d = bus.phi_in;
            if (boundary) begin
                act_d  = bus.phi_in;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (boundary && busy_q) begin
            act_d  = shadow_q;
            busy_d = 1'b0;
        end
    end

    // High half of the period is where (phase - phi) has its MSB clear.
    generate
        for (genvar gi = 0; gi < N_OSC; gi++) begin : g_osc
            logic [PH_W-1:0] diff;
            assign diff       = phase_d - act_d[gi*PH_W +: PH_W];
            assign nout_d[gi] = ~diff[PH_W-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            act_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            sync_q   <= 1'b0;
            nout_q   <= '1;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            tick_q   <= tick_ev;
            sync_q   <= boundary;
            nout_q   <= nout_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.nout      = nout_q;
    assign bus.phase_cnt = phase_q;
    assign bus.tick      = tick_q;
    assign bus.sync      = sync_q;
endmodule
